// File: rtl/calc_op_sequencer_if.sv
// Handshake and adder-side signals of the operand sequencer.
// The slave modport is the sequencer; the master modport is its environment (host plus adder).
interface calc_op_sequencer_if;
  logic [7:0] Data_In;
  logic       Load_A;
  logic       Load_B;
  logic [1:0] Op;
  logic       Use_Result;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [7:0] Result;
  logic [3:0] Flags;
  logic [7:0] Adder_A;
  logic [7:0] Adder_B;
  logic       Adder_Sub;
  logic [7:0] Adder_S;
  logic [3:0] Adder_Flags;

  modport slave (
    input  Data_In, Load_A, Load_B, Op, Use_Result, Start, Adder_S, Adder_Flags,
    output Busy, Done, Result, Flags, Adder_A, Adder_B, Adder_Sub
  );

  modport master (
    output Data_In, Load_A, Load_B, Op, Use_Result, Start, Adder_S, Adder_Flags,
    input  Busy, Done, Result, Flags, Adder_A, Adder_B, Adder_Sub
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Operand staging and sequencing in front of an external 8-bit adder/subtractor.
// Single-pass ADD/SUB/CMP; MUL as an 8-step shift-and-add loop through the same adder.
//
// state  | meaning
// IDLE   | operands loadable, waiting for Start
// EXEC   | single adder pass (ADD/SUB/CMP)
// MSTEP  | multiply loop, one partial product per cycle
// DONE   | Done pulse; behaves like IDLE for Start/loads
module calc_op_sequencer (
  input  logic                  Clk,
  input  logic                  Rst_n,
  calc_op_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MSTEP, S_DONE} state_t;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] mplier_q, mplier_d;
  logic [2:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;

  logic       ready;
  logic [7:0] a_eff;
  logic       busy;
  logic       done;
  logic [7:0] adder_a;
  logic [7:0] adder_b;
  logic       adder_sub;

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign a_eff = bus.Use_Result ? result_q : a_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 2'b00;
      acc_q    <= 8'h00;
      mcand_q  <= 8'h00;
      mplier_q <= 8'h00;
      cnt_q    <= 3'd0;
      carry_q  <= 1'b0;
      result_q <= 8'h00;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start)
          state_d = (bus.Op == OP_MUL) ? S_MSTEP : S_EXEC;
        else
          state_d = S_IDLE;
      end
      S_EXEC:  state_d = S_DONE;
      S_MSTEP: if (cnt_q == 3'd7) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (ready) begin
      if (bus.Start) begin
        op_d     = bus.Op;
        a_d      = a_eff;
        acc_d    = 8'h00;
        mcand_d  = a_eff;
        mplier_d = b_q;
        cnt_d    = 3'd0;
        carry_d  = 1'b0;
      end else begin
        if (bus.Load_A) a_d = bus.Data_In;
        if (bus.Load_B) b_d = bus.Data_In;
      end
    end else if (state_q == S_EXEC) begin
      flags_d = bus.Adder_Flags;
      if (op_q != OP_CMP) result_d = bus.Adder_S;
    end else if (state_q == S_MSTEP) begin
      acc_d    = bus.Adder_S;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 3'd1;
      // A multiplicand bit lost off the top still counts if a later multiplier bit would add it.
      carry_d  = carry_q | bus.Adder_Flags[3] | (mcand_q[7] & (|mplier_q[7:1]));
      if (cnt_q == 3'd7) begin
        result_d = bus.Adder_S;
        flags_d  = {carry_d, 1'b0, bus.Adder_S[7], (bus.Adder_S == 8'h00)};
      end
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    adder_a   = a_q;
    adder_b   = b_q;
    adder_sub = 1'b0;
    case (state_q)
      S_EXEC: begin
        busy      = 1'b1;
        adder_sub = (op_q == OP_SUB) || (op_q == OP_CMP);
      end
      S_MSTEP: begin
        busy    = 1'b1;
        adder_a = acc_q;
        adder_b = mplier_q[0] ? mcand_q : 8'h00;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.Result    = result_q;
  assign bus.Flags     = flags_q;
  assign bus.Adder_A   = adder_a;
  assign bus.Adder_B   = adder_b;
  assign bus.Adder_Sub = adder_sub;

endmodule
